// File: rtl/muldiv_seq.sv
// Iterative HI/LO multiply/divide sequencer: 32-step shift-add multiply and restoring divide.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module muldiv_seq (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] src_a_i,
   input  logic [31:0] src_b_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div_zero_o
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic        sa_q, sb_q, dz_q;
   logic [63:0] acc, ma;
   logic [31:0] mb;
   logic [31:0] rem, dq, dvs;

   logic        accept, last;
   logic        in_sa, in_sb;
   logic [31:0] in_mag_a, in_mag_b;
   logic [63:0] acc_nxt, prod_res;
   logic [32:0] shifted;
   logic        ge;
   logic [31:0] rem_nxt, dq_nxt, quo_res, rem_res;
   logic        neg;

   assign accept   = (state == S_IDLE) && start_i && !flush_i;
   assign last     = (cnt == 6'd31);
   assign in_sa    = !op_i[0] && src_a_i[31];
   assign in_sb    = !op_i[0] && src_b_i[31];
   // -0x8000_0000 wraps back to 0x8000_0000, which is the exact unsigned magnitude
   assign in_mag_a = in_sa ? (~src_a_i + 32'd1) : src_a_i;
   assign in_mag_b = in_sb ? (~src_b_i + 32'd1) : src_b_i;

   assign acc_nxt  = acc + (mb[0] ? ma : '0);
   assign shifted  = {rem, dq[31]};
   assign ge       = (shifted >= {1'b0, dvs});
   assign rem_nxt  = ge ? (shifted[31:0] - dvs) : shifted[31:0];
   assign dq_nxt   = {dq[30:0], ge};

   assign neg      = sa_q ^ sb_q;
   assign prod_res = neg ? (~acc_nxt + 64'd1) : acc_nxt;
   assign quo_res  = neg ? (~dq_nxt + 32'd1) : dq_nxt;
   assign rem_res  = sa_q ? (~rem_nxt + 32'd1) : rem_nxt;

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fast_prod;
   always_comb begin
      if (op_i[0])
         fast_prod = {32'd0, src_a_i} * {32'd0, src_b_i};
      else
         fast_prod = $signed({{32{src_a_i[31]}}, src_a_i}) * $signed({{32{src_b_i[31]}}, src_b_i});
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (op_i[1])
                  state_nxt = (src_b_i == '0) ? S_DONE : S_DIV;
               else
`ifdef MULDIV_FAST_MUL_EN
                  state_nxt = S_DONE;
`else
                  state_nxt = S_MUL;
`endif
            end
         end
         S_MUL:   if (last) state_nxt = S_DONE;
         S_DIV:   if (last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush_i) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         cnt   <= '0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
         dz_q  <= 1'b0;
         acc   <= '0;
         ma    <= '0;
         mb    <= '0;
         rem   <= '0;
         dq    <= '0;
         dvs   <= '0;
         hi_o  <= '0;
         lo_o  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  sa_q <= in_sa;
                  sb_q <= in_sb;
                  dz_q <= 1'b0;
                  cnt  <= '0;
                  acc  <= '0;
                  ma   <= {32'd0, in_mag_a};
                  mb   <= in_mag_b;
                  rem  <= '0;
                  dq   <= in_mag_a;
                  dvs  <= in_mag_b;
                  if (op_i[1] && (src_b_i == '0)) begin
                     dz_q <= 1'b1;
                     hi_o <= src_a_i;
                     lo_o <= '1;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  else if (!op_i[1]) begin
                     {hi_o, lo_o} <= fast_prod;
                  end
`endif
               end
            end
            S_MUL: begin
               acc <= acc_nxt;
               ma  <= ma << 1;
               mb  <= mb >> 1;
               cnt <= cnt + 6'd1;
               if (last && !flush_i) {hi_o, lo_o} <= prod_res;
            end
            S_DIV: begin
               rem <= rem_nxt;
               dq  <= dq_nxt;
               cnt <= cnt + 6'd1;
               if (last && !flush_i) begin
                  hi_o <= rem_res;
                  lo_o <= quo_res;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o     = (state != S_IDLE);
   assign done_o     = (state == S_DONE);
   assign div_zero_o = (state == S_DONE) && dz_q;
   assign stall_o    = (((state == S_IDLE) && start_i) || (state == S_MUL) || (state == S_DIV)) && !flush_i;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against a plain-arithmetic HI/LO model.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = '0;
   logic [31:0] src_a_i = '0;
   logic [31:0] src_b_i = '0;
   logic        flush_i = 1'b0;
   logic        stall_o, busy_o, done_o, div_zero_o;
   logic [31:0] hi_o, lo_o;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] last_hi = '0, last_lo = '0;

   always #5 clk = ~clk;

   muldiv_seq dut (
      .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
      .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
      .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
      .hi_o(hi_o), .lo_o(lo_o), .div_zero_o(div_zero_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // returns {div_zero, hi, lo}
   function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p, q, r;
      logic [63:0] ua, ub, up;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         2'b00: begin p = sa * sb; return {1'b0, p[63:0]}; end
         2'b01: begin up = ua * ub; return {1'b0, up}; end
         2'b10: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            return {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
      if (op[1]) return (b == 0) ? 1 : 33;
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [64:0] e;
      int lat, stalls, lim;
      bit seen;
      e = model(op, a, b);
      lim = exp_latency(op, b);
      @(negedge clk);
      start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b; flush_i = 1'b0;
      #1;
      check("busy_at_accept", busy_o, 0);
      seen = 0; stalls = 0; lat = 0;
      for (int k = 0; k < 40; k++) begin
         if (done_o) begin seen = 1; lat = k; break; end
         if (stall_o) stalls++;
         @(negedge clk);
      end
      check("done_seen", seen, 1);
      if (seen) begin
         check("latency", lat, lim);
         check("stall_cycles", stalls, lim);
         check("stall_in_done", stall_o, 0);
         check("hi", hi_o, e[63:32]);
         check("lo", lo_o, e[31:0]);
         check("div_zero", div_zero_o, e[64]);
         last_hi = e[63:32];
         last_lo = e[31:0];
      end
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] sp [5];
      sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      int dones;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_hi", hi_o, 0);
      check("rst_lo", lo_o, 0);
      check("rst_dz", div_zero_o, 0);
      @(negedge clk);
      resetn = 1'b1;

      run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      run_op(2'b11, 32'd100, 32'd7);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(2'b10, 32'h1234_5678, 32'd0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE);

      // flush mid-divide: no result, HI/LO keep prior values
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b11; src_a_i = 32'd1000; src_b_i = 32'd3;
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      #1;
      check("flush_stall", stall_o, 0);
      check("flush_done", done_o, 0);
      @(negedge clk);
      flush_i = 1'b0; start_i = 1'b0;
      #1;
      check("flush_idle", busy_o, 0);
      dones = 0;
      repeat (40) begin @(negedge clk); if (done_o) dones++; end
      check("flush_no_done", dones, 0);
      check("flush_hi_kept", hi_o, last_hi);
      check("flush_lo_kept", lo_o, last_lo);
      run_op(2'b11, 32'd9, 32'd3);

      // reset in cycle 5 of a MULT
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b00; src_a_i = 32'h1234_5678; src_b_i = 32'hFEDC_BA98;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("arst_busy", busy_o, 0);
      check("arst_done", done_o, 0);
      check("arst_hi", hi_o, 0);
      check("arst_lo", lo_o, 0);
      check("arst_dz", div_zero_o, 0);
      check("arst_stall_start", stall_o, 1);
      start_i = 1'b0;
      #1;
      check("arst_stall_idle", stall_o, 0);
      @(negedge clk);
      resetn = 1'b1;
      dones = 0;
      repeat (40) begin @(negedge clk); if (done_o) dones++; end
      check("arst_no_done", dones, 0);

      for (int i = 0; i < 60; i++) begin
         logic [1:0] op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a = rand_operand();
         b = rand_operand();
         run_op(op, a, b);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            start_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
            check("gap_idle", busy_o, 0);
         end
      end
      @(negedge clk);
      start_i = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
